// File: rtl/uart_pixel_packer_if.sv
// Byte-in / pixel-write-out bundle between the UART receiver, the pixel packer and the frame buffer.
// The master side supplies received bytes; the slave side (the packer) drives the frame buffer writes.
interface uart_pixel_packer_if #(
   parameter int ADDR_WIDTH = 14
);
   logic [7:0]            data_recv;
   logic                  data_recv_flag;
   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [15:0]           wr_data;
   logic                  frame_done;
   logic                  timeout_flag;
   logic                  busy;

   modport master (
      output data_recv, data_recv_flag,
      input  wr_en, wr_addr, wr_data, frame_done, timeout_flag, busy
   );

   modport slave (
      input  data_recv, data_recv_flag,
      output wr_en, wr_addr, wr_data, frame_done, timeout_flag, busy
   );
endinterface

// File: rtl/uart_pixel_packer.sv
// Pairs UART bytes into RGB565 pixels (high byte first) and writes them into the frame buffer.
// Defining PIXEL_HEADER_SYNC_EN requires a 0x55 0xAA header before each frame.
module uart_pixel_packer #(
   parameter int IMG_WIDTH    = 128,
   parameter int IMG_HEIGHT   = 128,
   parameter int ADDR_WIDTH   = 14,
   parameter int IDLE_TIMEOUT = 500_000
) (
   input logic                clock,
   input logic                reset,
   uart_pixel_packer_if.slave bus
);

   localparam int NUM_PIX = IMG_WIDTH * IMG_HEIGHT;
   localparam int CNT_W   = $clog2(IDLE_TIMEOUT + 1);
   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_PIX - 1);
   localparam logic [CNT_W-1:0]      CNT_MAX  = CNT_W'(IDLE_TIMEOUT - 1);

   typedef enum logic [1:0] {WAIT_HI, WAIT_LO, SYNC0, SYNC1} state_t;

`ifdef PIXEL_HEADER_SYNC_EN
   localparam state_t START_STATE = SYNC0;
`else
   localparam state_t START_STATE = WAIT_HI;
`endif

   state_t                r_state;
   logic [7:0]            r_hiByte;
   logic [ADDR_WIDTH-1:0] r_pixIdx;
   logic [CNT_W-1:0]      r_idleCnt;
   logic                  r_wrEn;
   logic [ADDR_WIDTH-1:0] r_wrAddr;
   logic [15:0]           r_wrData;
   logic                  r_frameDone;
   logic                  r_timeout;
   logic                  r_busy;

   state_t                w_nextState;
   logic [7:0]            w_nextHi;
   logic [ADDR_WIDTH-1:0] w_nextIdx;
   logic [CNT_W-1:0]      w_nextCnt;
   logic                  w_write;
   logic                  w_frameEnd;
   logic                  w_timeout;
   logic                  w_counting;

   // The idle counter only guards a frame in progress (and a half-seen header), never an idle line.
   assign w_counting = (r_state == WAIT_LO) || (r_pixIdx != '0) || (r_state == SYNC1);

   always_comb begin
      w_nextState = r_state;
      w_nextHi    = r_hiByte;
      w_nextIdx   = r_pixIdx;
      w_nextCnt   = '0;
      w_write     = 1'b0;
      w_frameEnd  = 1'b0;
      w_timeout   = 1'b0;
      if (bus.data_recv_flag) begin
         case (r_state)
            WAIT_HI: begin
               w_nextHi    = bus.data_recv;
               w_nextState = WAIT_LO;
            end
            WAIT_LO: begin
               w_write = 1'b1;
               if (r_pixIdx == LAST_IDX) begin
                  w_frameEnd  = 1'b1;
                  w_nextIdx   = '0;
                  w_nextState = START_STATE;
               end else begin
                  w_nextIdx   = r_pixIdx + ADDR_WIDTH'(1);
                  w_nextState = WAIT_HI;
               end
            end
`ifdef PIXEL_HEADER_SYNC_EN
            SYNC0: begin
               if (bus.data_recv == 8'h55) w_nextState = SYNC1;
            end
            SYNC1: begin
               if (bus.data_recv == 8'hAA)      w_nextState = WAIT_HI;
               else if (bus.data_recv != 8'h55) w_nextState = SYNC0;
            end
`endif
            default: w_nextState = START_STATE;
         endcase
      end else if (w_counting) begin
         if (r_idleCnt == CNT_MAX) begin
            w_timeout   = 1'b1;
            w_nextIdx   = '0;
            w_nextHi    = '0;
            w_nextState = START_STATE;
         end else begin
            w_nextCnt = r_idleCnt + CNT_W'(1);
         end
      end
   end

   // wr_addr trails the index by one clock, so it shows the written pixel during wr_en and then advances.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state     <= START_STATE;
         r_hiByte    <= '0;
         r_pixIdx    <= '0;
         r_idleCnt   <= '0;
         r_wrEn      <= 1'b0;
         r_wrAddr    <= '0;
         r_wrData    <= '0;
         r_frameDone <= 1'b0;
         r_timeout   <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_nextState;
         r_hiByte    <= w_nextHi;
         r_pixIdx    <= w_nextIdx;
         r_idleCnt   <= w_nextCnt;
         r_wrEn      <= w_write;
         r_wrAddr    <= r_pixIdx;
         r_frameDone <= w_frameEnd;
         r_timeout   <= w_timeout;
         r_busy      <= (w_nextState == WAIT_LO) || (w_nextIdx != '0);
         if (w_write) r_wrData <= {r_hiByte, bus.data_recv};
      end
   end

   assign bus.wr_en        = r_wrEn;
   assign bus.wr_addr      = r_wrAddr;
   assign bus.wr_data      = r_wrData;
   assign bus.frame_done   = r_frameDone;
   assign bus.timeout_flag = r_timeout;
   assign bus.busy         = r_busy;

endmodule

// File: tb/tb_uart_pixel_packer.sv
// Directed self-checking bench for uart_pixel_packer on a 4x2 frame with a 100-clock idle timeout.
// Header bytes are sent at each frame start only when PIXEL_HEADER_SYNC_EN is defined.
module tb_uart_pixel_packer;

   localparam int IW = 4;
   localparam int IH = 2;
   localparam int AW = 3;
   localparam int TO = 100;

   logic clock = 1'b0;
   logic reset;
   int   checkCount = 0;
   int   passCount  = 0;
   int   failCount  = 0;

   uart_pixel_packer_if #(.ADDR_WIDTH(AW)) pixBus ();

   uart_pixel_packer #(
      .IMG_WIDTH(IW), .IMG_HEIGHT(IH), .ADDR_WIDTH(AW), .IDLE_TIMEOUT(TO)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus(pixBus)
   );

   always #5 clock = ~clock;

   // Every byte is presented at a falling edge, so the task returns just after the edge that consumed it.
   task automatic applyStimulus(input logic [7:0] b);
      pixBus.data_recv      = b;
      pixBus.data_recv_flag = 1'b1;
      @(negedge clock);
      pixBus.data_recv_flag = 1'b0;
   endtask

   task automatic idleClocks(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic sendHeader();
`ifdef PIXEL_HEADER_SYNC_EN
      applyStimulus(8'h55);
      applyStimulus(8'hAA);
`endif
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      assert (obs === exp) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic checkWrite(input string tag, input int addr, input int data, input bit done);
      checkOutput({tag, "_wr_en"}, 32'(pixBus.wr_en), 32'd1);
      checkOutput({tag, "_wr_addr"}, 32'(pixBus.wr_addr), 32'(addr));
      checkOutput({tag, "_wr_data"}, 32'(pixBus.wr_data), 32'(data));
      checkOutput({tag, "_frame_done"}, 32'(pixBus.frame_done), 32'(done));
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_wr_en"}, 32'(pixBus.wr_en), 32'd0);
      checkOutput({tag, "_wr_addr"}, 32'(pixBus.wr_addr), 32'd0);
      checkOutput({tag, "_wr_data"}, 32'(pixBus.wr_data), 32'd0);
      checkOutput({tag, "_frame_done"}, 32'(pixBus.frame_done), 32'd0);
      checkOutput({tag, "_timeout"}, 32'(pixBus.timeout_flag), 32'd0);
      checkOutput({tag, "_busy"}, 32'(pixBus.busy), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog expired before the sequence completed");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int toSeen;
      int doneSeen;
      int pix;

      reset                 = 1'b1;
      pixBus.data_recv      = 8'h00;
      pixBus.data_recv_flag = 1'b0;
      @(negedge clock);
      checkAllZero("reset");
      reset = 1'b0;
      @(negedge clock);

      // One full frame of bytes 0x00..0x0F.
      sendHeader();
      for (int p = 0; p < 8; p++) begin
         applyStimulus(8'(2 * p));
         checkOutput($sformatf("f1_hi%0d_wr_en", p), 32'(pixBus.wr_en), 32'd0);
         checkOutput($sformatf("f1_hi%0d_busy", p), 32'(pixBus.busy), 32'd1);
         applyStimulus(8'(2 * p + 1));
         checkWrite($sformatf("f1_px%0d", p), p, ((2 * p) << 8) | (2 * p + 1), p == 7);
      end
      checkOutput("f1_busy_after", 32'(pixBus.busy), 32'd0);

      // An idle line between frames must never time out.
      toSeen = 0;
      repeat (150) begin
         @(negedge clock);
         if (pixBus.timeout_flag) toSeen++;
      end
      checkOutput("idle_line_no_timeout", 32'(toSeen), 32'd0);

      // Two frames with a flag on every clock.
      doneSeen = 0;
      pix      = 0;
      for (int f = 0; f < 2; f++) begin
         sendHeader();
         for (int p = 0; p < 8; p++) begin
            applyStimulus(8'(8'hA0 + p));
            applyStimulus(8'(8'h30 + p + f));
            checkWrite($sformatf("b2b_f%0d_px%0d", f, p), p,
                       ((8'hA0 + p) << 8) | (8'h30 + p + f), p == 7);
            if (pixBus.frame_done) doneSeen++;
            pix++;
         end
      end
      checkOutput("b2b_write_count", 32'(pix), 32'd16);
      checkOutput("b2b_frame_done_count", 32'(doneSeen), 32'd2);

      // Three bytes then silence: one write, then a timeout on the 100th idle clock.
      sendHeader();
      applyStimulus(8'h00);
      applyStimulus(8'h01);
      checkWrite("to_px0", 0, 16'h0001, 1'b0);
      applyStimulus(8'h02);
      idleClocks(TO - 1);
      checkOutput("to_before_expiry", 32'(pixBus.timeout_flag), 32'd0);
      checkOutput("to_busy_before", 32'(pixBus.busy), 32'd1);
      idleClocks(1);
      checkOutput("to_pulse", 32'(pixBus.timeout_flag), 32'd1);
      checkOutput("to_busy_after", 32'(pixBus.busy), 32'd0);
      checkOutput("to_no_write", 32'(pixBus.wr_en), 32'd0);
      idleClocks(1);
      checkOutput("to_pulse_end", 32'(pixBus.timeout_flag), 32'd0);
      sendHeader();
      applyStimulus(8'hAB);
      applyStimulus(8'hCD);
      checkWrite("to_resync", 0, 16'hABCD, 1'b0);

      // Reset with a high byte pending clears everything.
      applyStimulus(8'h77);
      #1 reset = 1'b1;
      #1 checkAllZero("midreset");
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      sendHeader();
      applyStimulus(8'h12);
      applyStimulus(8'h34);
      checkWrite("after_reset", 0, 16'h1234, 1'b0);

      // Low byte lands exactly on the expiry clock and wins.
      applyStimulus(8'h5A);
      idleClocks(TO - 1);
      applyStimulus(8'h3C);
      checkWrite("expiry_edge", 1, 16'h5A3C, 1'b0);
      checkOutput("expiry_no_timeout", 32'(pixBus.timeout_flag), 32'd0);
      checkOutput("expiry_busy", 32'(pixBus.busy), 32'd1);

`ifdef PIXEL_HEADER_SYNC_EN
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      applyStimulus(8'h01);
      checkOutput("nohdr_b0_wr_en", 32'(pixBus.wr_en), 32'd0);
      applyStimulus(8'h02);
      checkOutput("nohdr_b1_wr_en", 32'(pixBus.wr_en), 32'd0);
      applyStimulus(8'h11);
      applyStimulus(8'h55);
      applyStimulus(8'h55);
      applyStimulus(8'hAA);
      checkOutput("hdr_wr_en", 32'(pixBus.wr_en), 32'd0);
      applyStimulus(8'h01);
      applyStimulus(8'h02);
      checkWrite("hdr_px0", 0, 16'h0102, 1'b0);
`endif

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/uart_pixel_packer.md
Name: uart_pixel_packer

Overview:
- Sits directly downstream of the UART receiver in the UART-to-HDMI picture path.
- Consumes the received byte stream (data_recv / data_recv_flag), pairs bytes into RGB565 pixels (high byte first), and drives write strobes/addresses into the dual-port frame buffer read by the HDMI scan-out.
- Resynchronises to frame start on line idle (timeout); optional header-sync mode.

Parameters:
IMG_WIDTH, 128, pixels per line
IMG_HEIGHT, 128, lines per frame
ADDR_WIDTH, 14, frame buffer address width; must satisfy 2^ADDR_WIDTH >= IMG_WIDTH*IMG_HEIGHT
IDLE_TIMEOUT, 500_000, clocks without a byte mid-frame before resync (10 ms at 50 MHz)

Ports:
clock  input  1  system clock (50 MHz)
reset  input  1  asynchronous, active-high reset
data_recv  input  8  received byte from UART receiver
data_recv_flag  input  1  one-clock pulse, data_recv valid
wr_en  output  1  one-clock frame buffer write strobe
wr_addr  output  ADDR_WIDTH  pixel address, 0 .. IMG_WIDTH*IMG_HEIGHT-1
wr_data  output  16  RGB565 pixel {high_byte, low_byte}
frame_done  output  1  one-clock pulse with the last pixel write of a frame
timeout_flag  output  1  one-clock pulse when an idle resync occurs
busy  output  1  high while a frame is partially received

Behaviour:
- Reset (async, active-high): wr_en=0, wr_addr=0, wr_data=0, frame_done=0, timeout_flag=0, busy=0, high-byte reg=0, idle counter=0, state=WAIT_HI (SYNC0 with PIXEL_HEADER_SYNC_EN).
- Reset mid-frame discards the partial pixel and frame; next byte is treated as a high byte (or header byte).
- States (base): WAIT_HI, WAIT_LO.
  - WAIT_HI + data_recv_flag: latch data_recv as high byte -> WAIT_LO.
  - WAIT_LO + data_recv_flag: next clock wr_en=1, wr_data={high, data_recv}, wr_addr=current pixel index -> WAIT_HI.
- Latency: wr_en asserts exactly 1 clock after the low-byte flag; all outputs registered.
- Address: wr_addr holds the index of the pixel being written; increments by 1 the cycle after each write.
- Last pixel (index IMG_WIDTH*IMG_HEIGHT-1): frame_done=1 in the same cycle as its wr_en; index then wraps to 0. No write ever exceeds the last index.
- busy=1 whenever state != WAIT_HI or pixel index != 0 (SYNC states count as not busy).
- Idle counter: clears on every data_recv_flag; counts while busy=1 and no flag present.
  - Reaching IDLE_TIMEOUT-1: timeout_flag pulse, index->0, state->WAIT_HI (SYNC0), counter->0, partial high byte dropped, no write.
  - Flag in the same cycle the counter would expire: byte is accepted, counter cleared, no timeout.
  - Counter does not run while not busy (no timeout pulses on an idle line between frames).
- Flags arriving on consecutive clocks are all accepted (no throughput limit within the block).
- data_recv is sampled only on data_recv_flag cycles; ignored otherwise.

Optional Feature:
- Macro: PIXEL_HEADER_SYNC_EN.
- Defined: adds states SYNC0, SYNC1, entered at reset, after frame_done and after timeout.
  - SYNC0: byte 0x55 -> SYNC1; any other byte stays in SYNC0.
  - SYNC1: 0xAA -> WAIT_HI; 0x55 -> stay in SYNC1; anything else -> SYNC0.
  - Header bytes never produce writes. The idle counter also runs in SYNC1 and expiry returns to SYNC0.
- Undefined: no header; the frame starts at the first byte after reset, frame_done or timeout.

Test Plan:
- (IMG_WIDTH=4, IMG_HEIGHT=2, IDLE_TIMEOUT=100) Send 16 bytes 0x00..0x0F -> 8 writes, addr 0..7, data 0x0001, 0x0203 .. 0x0E0F; frame_done with the addr-7 write; busy=0 afterwards.
- Send 3 bytes, then idle for 100 clocks -> one write (addr 0, 0x0001), timeout_flag pulse, busy=0. Next bytes 0xAB, 0xCD -> write addr 0, data 0xABCD.
- Back-to-back flags every clock for 2 frames -> 16 writes, wr_addr wraps 7 -> 0, two frame_done pulses, no dropped bytes.
- Assert reset after a high byte mid-frame -> all outputs 0. Next pair 0x12, 0x34 -> write addr 0, 0x1234.
- Flag on exactly the expiry cycle (99 idle clocks then flag) -> no timeout_flag; the byte is accepted as a low byte and written.
- PIXEL_HEADER_SYNC_EN: send 0x11, 0x55, 0x55, 0xAA, 0x01, 0x02 -> single write addr 0, data 0x0102. Without the header bytes, pixel bytes are ignored (no wr_en).
